// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: IF/ID/EX/MEM/WB sequencer for the multi-cycle RV32I core.
// Outputs decode the state, qualified by mem_ready/alu_bcond, and are forced idle while in reset.
module multicycle_control_fsm (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       alu_bcond,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_src,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       wb_sel,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [4:0] alu_op,
  output logic       is_halted
);
  // ALU command encodings, mirroring the shared COMMAND.v macros
  localparam logic [4:0] ALU_ADDER           = 5'd0;
  localparam logic [4:0] ARITHMETIC_ADD      = 5'd1;
  localparam logic [4:0] ARITHMETIC_SUB      = 5'd2;
  localparam logic [4:0] ARITHMETIC_SLL      = 5'd3;
  localparam logic [4:0] ARITHMETIC_XOR      = 5'd4;
  localparam logic [4:0] ARITHMETIC_SRL      = 5'd5;
  localparam logic [4:0] ARITHMETIC_OR       = 5'd6;
  localparam logic [4:0] ARITHMETIC_AND      = 5'd7;
  localparam logic [4:0] ARITHMETIC_IMM_ADDI = 5'd8;
  localparam logic [4:0] ARITHMETIC_IMM_SLLI = 5'd9;
  localparam logic [4:0] ARITHMETIC_IMM_XORI = 5'd10;
  localparam logic [4:0] ARITHMETIC_IMM_SRLI = 5'd11;
  localparam logic [4:0] ARITHMETIC_IMM_ORI  = 5'd12;
  localparam logic [4:0] ARITHMETIC_IMM_ANDI = 5'd13;
  localparam logic [4:0] LOAD_LW             = 5'd14;
  localparam logic [4:0] STORE_SW            = 5'd15;
  localparam logic [4:0] BRANCH_BEQ          = 5'd16;
  localparam logic [4:0] BRANCH_BNE          = 5'd17;
  localparam logic [4:0] BRANCH_BLT          = 5'd18;
  localparam logic [4:0] BRANCH_BGE          = 5'd19;
  localparam logic [4:0] JALR_JALR           = 5'd20;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_ST   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_SYS  = 7'b1110011;
  typedef enum logic [3:0] {
    S_IF, S_ID, S_EX_R, S_EX_I, S_WB_ALU, S_EX_ADDR, S_MEM_RD,
    S_WB_MEM, S_MEM_WR, S_EX_BR, S_BR_TGT, S_EX_JAL, S_EX_JALR, S_HALT
  } state_t;
  state_t     r_state;
  logic       w_known;
  logic       w_br_valid;
  logic       w_taken;
  logic [4:0] w_r_op;
  logic [4:0] w_i_op;
  logic [4:0] w_br_op;
  assign w_known    = opcode inside {OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_JAL, OP_JALR, OP_SYS};
  assign w_br_valid = funct3 inside {3'b000, 3'b001, 3'b100, 3'b101};
  assign w_taken    = w_br_valid & alu_bcond;
  always_comb begin
    w_r_op  = ARITHMETIC_ADD;
    w_i_op  = ARITHMETIC_IMM_ADDI;
    w_br_op = ALU_ADDER;
    case (funct3)
      3'b000: begin
        w_r_op  = funct7_5 ? ARITHMETIC_SUB : ARITHMETIC_ADD;
        w_br_op = BRANCH_BEQ;
      end
      3'b001: begin
        w_r_op  = ARITHMETIC_SLL;
        w_i_op  = ARITHMETIC_IMM_SLLI;
        w_br_op = BRANCH_BNE;
      end
      3'b100: begin
        w_r_op  = ARITHMETIC_XOR;
        w_i_op  = ARITHMETIC_IMM_XORI;
        w_br_op = BRANCH_BLT;
      end
      3'b101: begin
        w_r_op  = ARITHMETIC_SRL;
        w_i_op  = ARITHMETIC_IMM_SRLI;
        w_br_op = BRANCH_BGE;
      end
      3'b110: begin
        w_r_op = ARITHMETIC_OR;
        w_i_op = ARITHMETIC_IMM_ORI;
      end
      3'b111: begin
        w_r_op = ARITHMETIC_AND;
        w_i_op = ARITHMETIC_IMM_ANDI;
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IF;
    else begin
      case (r_state)
        S_IF:      r_state <= mem_ready ? S_ID : S_IF;
        S_ID: begin
          case (opcode)
            OP_R:         r_state <= S_EX_R;
            OP_I:         r_state <= S_EX_I;
            OP_LD, OP_ST: r_state <= S_EX_ADDR;
            OP_BR:        r_state <= S_EX_BR;
            OP_JAL:       r_state <= S_EX_JAL;
            OP_JALR:      r_state <= S_EX_JALR;
            OP_SYS:       r_state <= S_HALT;
            default:      r_state <= S_IF;
          endcase
        end
        S_EX_R, S_EX_I: r_state <= S_WB_ALU;
        S_EX_ADDR: r_state <= (opcode == OP_LD) ? S_MEM_RD : S_MEM_WR;
        S_MEM_RD:  r_state <= mem_ready ? S_WB_MEM : S_MEM_RD;
        S_MEM_WR:  r_state <= mem_ready ? S_IF : S_MEM_WR;
        S_EX_BR:   r_state <= w_taken ? S_BR_TGT : S_IF;
        S_HALT:    r_state <= S_HALT;
        default:   r_state <= S_IF;
      endcase
    end
  end
  // reset_n gates the decode so nothing is enabled while reset is held
  always_comb begin
    pc_write  = 1'b0;
    pc_src    = 1'b0;
    i_or_d    = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    ir_write  = 1'b0;
    reg_write = 1'b0;
    wb_sel    = 1'b0;
    alu_src_a = 1'b0;
    alu_src_b = 2'd0;
    alu_op    = ALU_ADDER;
    is_halted = 1'b0;
    if (reset_n) begin
      case (r_state)
        S_IF: begin
          mem_read = 1'b1;
          ir_write = mem_ready;
        end
        S_ID: begin
          alu_src_b = 2'd1;
          pc_write  = !w_known;
        end
        S_EX_R: begin
          alu_src_a = 1'b1;
          alu_op    = w_r_op;
        end
        S_EX_I: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'd2;
          alu_op    = w_i_op;
        end
        S_WB_ALU, S_WB_MEM: begin
          reg_write = 1'b1;
          wb_sel    = (r_state == S_WB_MEM);
          alu_src_b = 2'd1;
          pc_write  = 1'b1;
        end
        S_EX_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'd2;
          alu_op    = (opcode == OP_LD) ? LOAD_LW : STORE_SW;
        end
        S_MEM_RD: begin
          i_or_d   = 1'b1;
          mem_read = 1'b1;
        end
        S_MEM_WR: begin
          i_or_d    = 1'b1;
          mem_write = 1'b1;
          pc_write  = mem_ready;
          alu_src_b = mem_ready ? 2'd1 : 2'd0;
        end
        S_EX_BR: begin
          alu_src_a = 1'b1;
          alu_op    = w_br_op;
          pc_write  = !w_taken;
          pc_src    = !w_taken;
        end
        S_BR_TGT: begin
          alu_src_b = 2'd2;
          pc_write  = 1'b1;
        end
        S_EX_JAL, S_EX_JALR: begin
          reg_write = 1'b1;
          pc_write  = 1'b1;
          alu_src_a = (r_state == S_EX_JALR);
          alu_src_b = 2'd2;
          alu_op    = (r_state == S_EX_JALR) ? JALR_JALR : ALU_ADDER;
        end
        S_HALT:  is_halted = 1'b1;
        default: ;
      endcase
    end
  end
endmodule
